// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default widths and the
// branch-resolution rule, reused by the CPU top level and decode.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int INSTR_W_DEF = 26;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // A zero-conditional branch only goes when the ALU reported zero.
  function automatic logic branch_taken(input logic en, input logic on_zero, input logic zflag);
    return en & (~on_zero | zflag);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control from decode/ALU, the external ROM port and the
// instruction register outputs.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  logic               stall;
  logic               branch_en;
  logic               branch_zero;
  logic               zflag;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt_req;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  modport slave (
    input  stall, branch_en, branch_zero, zflag, branch_target, halt_req, rom_data,
    output rom_addr, instr, instr_valid, pc, halted
  );

  modport master (
    output stall, branch_en, branch_zero, zflag, branch_target, halt_req, rom_data,
    input  rom_addr, instr, instr_valid, pc, halted
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch address register: synchronous clear, then load, then increment, else hold.
// The increment wraps naturally at the top of the address space.
module fetch_pc_reg #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the ROM address, registers the returned word
// with its pc, inserts a bubble on taken branches and stops for good on halt.
//
//   state | meaning
//   RESET | one settling cycle after rst drops, no capture
//   RUN   | fetching: sequential, stalled or redirecting on a branch
//   HALT  | fetching stopped; only rst leaves
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q, valid_d;
  logic               capture;
  logic               pc_load;
  logic               pc_inc;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    capture = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      RESET: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        // halt beats stall, stall beats branch; a stalled branch waits in decode
        if (bus.halt_req) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          valid_d = valid_q;
        end else if (branch_taken(bus.branch_en, bus.branch_zero, bus.zflag)) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          valid_d = 1'b1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RESET;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (capture) begin
        instr_q <= bus.rom_data;
        pc_q    <= bus.rom_addr;
      end
    end
  end

  fetch_pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (bus.branch_target),
    .inc       (pc_inc),
    .addr      (bus.rom_addr)
  );

  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, all checked
// against a behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int AW    = 6;
  localparam int IW    = 26;
  localparam int DEPTH = 64;
  localparam int OW    = 2*AW + IW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] rom [DEPTH];
  assign bus.rom_data = rom[bus.rom_addr];

  // model: mode 0 = waiting out the reset cycle, 1 = fetching, 2 = stopped
  int            m_mode;
  int            m_addr;
  int            m_pc;
  logic [IW-1:0] m_instr;
  bit            m_valid;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [OW-1:0] obs();
    return {bus.rom_addr, bus.pc, bus.instr, bus.instr_valid, bus.halted};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {AW'(m_addr), AW'(m_pc), m_instr, m_valid, (m_mode == 2)};
  endfunction

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_zero   = 1'b0;
    bus.zflag         = 1'b0;
    bus.branch_target = '0;
    bus.halt_req      = 1'b0;
  endtask

  // Advance the model by the inputs present at the coming edge, then the DUT.
  task automatic tick();
    if (rst) begin
      m_mode = 0; m_addr = 0; m_pc = 0; m_instr = '0; m_valid = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.halt_req) begin
        m_mode = 2; m_valid = 0;
      end else if (bus.stall) begin
        m_valid = m_valid;
      end else if (bus.branch_en && (!bus.branch_zero || bus.zflag)) begin
        m_addr = int'(bus.branch_target); m_valid = 0;
      end else begin
        m_instr = rom[m_addr]; m_pc = m_addr; m_valid = 1;
        m_addr  = (m_addr + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_pc(input int target);
    int k;
    k = 0;
    while (!(m_valid && m_mode == 1 && m_pc == target) && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= 200 || obs() !== expv())
      $display("FAIL run_to_pc_%0d: got %h want %h (cycles %0d)", target, obs(), expv(), k);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'(i);
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs() !== '0) $display("FAIL reset_state: got %h want 0", obs());
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 6'd0 || obs() !== expv())
      $display("FAIL reset_cycle: got %h want %h", obs(), expv());
    else n_pass++;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 26'd0 || bus.pc !== 6'd0 || bus.rom_addr !== 6'd1)
      $display("FAIL first_fetch: got %h want valid=1 instr=0 pc=0 rom_addr=1", obs());
    else n_pass++;
  endtask

  task automatic test_sequential();
    int prev_pc;
    prev_pc = int'(bus.pc);
    for (int k = 0; k < 70; k++) begin
      tick();
      n_checks++;
      if (obs() !== expv() || bus.instr_valid !== 1'b1 || bus.instr !== IW'(bus.pc)
          || int'(bus.pc) != (prev_pc + 1) % DEPTH)
        $display("FAIL sequential_%0d: got %h want %h prev_pc %0d", k, obs(), expv(), prev_pc);
      else n_pass++;
      prev_pc = int'(bus.pc);
    end
  endtask

  task automatic test_branch();
    run_to_pc(5);
    bus.branch_en = 1'b1; bus.branch_zero = 1'b1; bus.zflag = 1'b0; bus.branch_target = 6'd20;
    tick();
    n_checks++;
    if (bus.instr !== rom[6] || bus.pc !== 6'd6 || bus.instr_valid !== 1'b1 || obs() !== expv())
      $display("FAIL branch_not_taken: got %h want instr=%h pc=6", obs(), rom[6]);
    else n_pass++;
    bus.zflag = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.rom_addr !== 6'd20 || bus.pc !== 6'd6 || bus.instr !== rom[6])
      $display("FAIL branch_bubble: got %h want valid=0 rom_addr=20 pc=6", obs());
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (bus.instr !== rom[20] || bus.pc !== 6'd20 || bus.instr_valid !== 1'b1 || obs() !== expv())
      $display("FAIL branch_target_fetch: got %h want instr=%h pc=20", obs(), rom[20]);
    else n_pass++;
    bus.branch_en = 1'b1; bus.branch_zero = 1'b0; bus.zflag = 1'b0; bus.branch_target = 6'd50;
    tick();
    idle_inputs();
    n_checks++;
    if (bus.rom_addr !== 6'd50 || bus.instr_valid !== 1'b0 || obs() !== expv())
      $display("FAIL branch_unconditional: got %h want rom_addr=50 valid=0", obs());
    else n_pass++;
  endtask

  task automatic test_stall();
    run_to_pc(10);
    bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 6'd40;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.pc !== 6'd10 || bus.instr !== rom[10] || bus.instr_valid !== 1'b1 || bus.rom_addr !== 6'd11)
        $display("FAIL stall_hold_%0d: got %h want pc=10 valid=1 rom_addr=11", k, obs());
      else n_pass++;
    end
    bus.stall = 1'b0;
    tick();
    n_checks++;
    if (bus.rom_addr !== 6'd40 || bus.instr_valid !== 1'b0 || bus.pc !== 6'd10)
      $display("FAIL stall_release_branch: got %h want rom_addr=40 valid=0 pc=10", obs());
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (bus.pc !== 6'd40 || bus.instr !== rom[40] || bus.instr_valid !== 1'b1 || obs() !== expv())
      $display("FAIL stall_branch_fetch: got %h want pc=40 instr=%h", obs(), rom[40]);
    else n_pass++;
  endtask

  task automatic test_halt();
    run_to_pc(12);
    bus.halt_req = 1'b1; bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 6'd3;
    tick();
    n_checks++;
    if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.rom_addr !== 6'd13 || bus.pc !== 6'd12)
      $display("FAIL halt_enter: got %h want halted=1 valid=0 rom_addr=13 pc=12", obs());
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      bus.halt_req      = 1'($urandom_range(0, 1));
      bus.stall         = 1'($urandom_range(0, 1));
      bus.branch_en     = 1'($urandom_range(0, 1));
      bus.branch_zero   = 1'($urandom_range(0, 1));
      bus.zflag         = 1'($urandom_range(0, 1));
      bus.branch_target = AW'($urandom);
      tick();
      n_checks++;
      if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.rom_addr !== 6'd13
          || bus.pc !== 6'd12 || obs() !== expv())
        $display("FAIL halt_frozen_%0d: got %h want %h", k, obs(), expv());
      else n_pass++;
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b1 || bus.pc !== 6'd0 || bus.instr !== rom[0])
      $display("FAIL halt_restart: got %h want halted=0 valid=1 pc=0 instr=%h", obs(), rom[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_branch();
    run_to_pc(7);
    bus.branch_en = 1'b1; bus.branch_zero = 1'b0; bus.branch_target = 6'd30;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.rom_addr !== 6'd0 || bus.instr_valid !== 1'b0 || bus.pc !== 6'd0)
      $display("FAIL reset_mid_branch: got %h want rom_addr=0 valid=0 pc=0", obs());
    else n_pass++;
    idle_inputs();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (bus.pc !== AW'(k) || bus.instr !== rom[k] || bus.instr_valid !== 1'b1 || obs() !== expv())
        $display("FAIL reset_mid_branch_seq_%0d: got %h want pc=%0d instr=%h", k, obs(), k, rom[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
    for (int k = 0; k < 3000; k++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.halt_req      = ($urandom_range(0, 149) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_en     = ($urandom_range(0, 5) == 0);
      bus.branch_zero   = 1'($urandom_range(0, 1));
      bus.zflag         = 1'($urandom_range(0, 1));
      bus.branch_target = AW'($urandom);
      tick();
      n_checks++;
      if (obs() !== expv())
        $display("FAIL random_%0d: got %h want %h", k, obs(), expv());
      else n_pass++;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    m_mode = 0; m_addr = 0; m_pc = 0; m_instr = '0; m_valid = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_reset_mid_branch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
